// File: rtl/video_scanout.sv
// +--------------------------------------------------------------------------+
// | video_scanout                                                            |
// | Raster timing and row-word serialiser for the framebuffer read port.     |
// | Optional: define SCANOUT_ZOOM2_EN for 2x horizontal/vertical zoom.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module video_scanout #(
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          V_ACTIVE  = 24,
   parameter int          PIX_DIV   = 1,
   parameter int          H_FRONT   = 2,
   parameter int          H_SYNC    = 4,
   parameter int          H_BACK    = 2,
   parameter int          V_FRONT   = 1,
   parameter int          V_SYNC    = 2,
   parameter int          V_BACK    = 1,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        en_i,
   output logic [31:0] va_o,
   input  logic [31:0] vdr_i,
   input  logic [31:0] vdg_i,
   input  logic [31:0] vdb_i,
   output logic        pix_r_o,
   output logic        pix_g_o,
   output logic        pix_b_o,
   output logic        pix_valid_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        frame_start_o
);

`ifdef SCANOUT_ZOOM2_EN
   localparam int ZOOM = 1;
`else
   localparam int ZOOM = 0;
`endif

   localparam int H_ACT   = 32 << ZOOM;
   localparam int V_VIS   = V_ACTIVE << ZOOM;
   localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACT);
   localparam logic [HW-1:0] C_HS_START = HW'(H_ACT + H_FRONT);
   localparam logic [HW-1:0] C_HS_END   = HW'(H_ACT + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] C_V_VIS    = VW'(V_VIS);
   localparam logic [VW-1:0] C_VS_START = VW'(V_VIS + V_FRONT);
   localparam logic [VW-1:0] C_VS_END   = VW'(V_VIS + V_FRONT + V_SYNC);
   localparam logic [DW-1:0] C_DIV_LAST = DW'(PIX_DIV - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          w_clear, w_load, w_run, w_tick;

   logic [HW-1:0] hcnt_q, hcnt_d, w_h_n;
   logic [VW-1:0] vcnt_q, vcnt_d, w_v_n, w_v_next, w_row;
   logic [DW-1:0] div_q, div_d;
   logic [31:0]   va_q, va_d, w_fetch_addr;
   logic [31:0]   sh_r_q, sh_r_d, sh_g_q, sh_g_d, sh_b_q, sh_b_d;
   logic          pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
   logic          pix_valid_q, pix_valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic          frame_start_q, frame_start_d;
   logic          w_h_last, w_v_last, w_next_vis, w_act_n, w_shift;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  state_d = S_PRIME;
            S_PRIME: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_clear = (state_q == S_IDLE) || !en_i;
      w_load  = (state_q == S_PRIME) && en_i;
      w_run   = (state_q == S_RUN) && en_i;
   end

   assign w_tick       = w_run && (div_q == C_DIV_LAST);
   assign w_h_last     = (hcnt_q == C_H_LAST);
   assign w_v_last     = (vcnt_q == C_V_LAST);
   assign w_h_n        = w_h_last ? '0 : hcnt_q + 1'b1;
   assign w_v_next     = w_v_last ? '0 : vcnt_q + 1'b1;
   assign w_v_n        = w_h_last ? w_v_next : vcnt_q;
   assign w_next_vis   = (w_v_next < C_V_VIS);
   assign w_act_n      = (w_h_n < C_H_ACT) && (w_v_n < C_V_VIS);
   assign w_row        = w_v_next >> ZOOM;
   assign w_fetch_addr = BASE_ADDR + {{(30 - VW){1'b0}}, w_row, 2'b00};
`ifdef SCANOUT_ZOOM2_EN
   // Odd columns repeat the previous pixel, so the shifter steps every other tick.
   assign w_shift      = ~w_h_n[0];
`else
   assign w_shift      = 1'b1;
`endif

   always_comb begin
      hcnt_d = hcnt_q;   vcnt_d = vcnt_q;   div_d = div_q;   va_d = va_q;
      sh_r_d = sh_r_q;   sh_g_d = sh_g_q;   sh_b_d = sh_b_q;
      pix_r_d = pix_r_q; pix_g_d = pix_g_q; pix_b_d = pix_b_q;
      pix_valid_d = pix_valid_q;
      hsync_d = hsync_q; vsync_d = vsync_q;
      frame_start_d = 1'b0;
      if (w_clear) begin
         hcnt_d = '0; vcnt_d = '0; div_d = '0; va_d = BASE_ADDR;
         sh_r_d = '0; sh_g_d = '0; sh_b_d = '0;
         pix_r_d = 1'b0; pix_g_d = 1'b0; pix_b_d = 1'b0; pix_valid_d = 1'b0;
         hsync_d = ~SYNC_POL; vsync_d = ~SYNC_POL;
      end else if (w_load) begin
         sh_r_d = {vdr_i[30:0], 1'b0}; pix_r_d = vdr_i[31];
         sh_g_d = {vdg_i[30:0], 1'b0}; pix_g_d = vdg_i[31];
         sh_b_d = {vdb_i[30:0], 1'b0}; pix_b_d = vdb_i[31];
         pix_valid_d   = 1'b1;
         frame_start_d = 1'b1;
      end else if (w_run) begin
         div_d = w_tick ? '0 : div_q + 1'b1;
         if (w_tick) begin
            hcnt_d = w_h_n;
            vcnt_d = w_v_n;
            frame_start_d = w_h_last && w_v_last;
            hsync_d = (w_h_n >= C_HS_START && w_h_n < C_HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d = (w_v_n >= C_VS_START && w_v_n < C_VS_END) ? SYNC_POL : ~SYNC_POL;
            if (w_h_n == C_HS_START && w_next_vis) va_d = w_fetch_addr;
            pix_valid_d = w_act_n;
            if (w_h_last && w_next_vis) begin
               sh_r_d = {vdr_i[30:0], 1'b0}; pix_r_d = vdr_i[31];
               sh_g_d = {vdg_i[30:0], 1'b0}; pix_g_d = vdg_i[31];
               sh_b_d = {vdb_i[30:0], 1'b0}; pix_b_d = vdb_i[31];
            end else if (!w_act_n) begin
               pix_r_d = 1'b0; pix_g_d = 1'b0; pix_b_d = 1'b0;
            end else if (w_shift) begin
               pix_r_d = sh_r_q[31]; sh_r_d = {sh_r_q[30:0], 1'b0};
               pix_g_d = sh_g_q[31]; sh_g_d = {sh_g_q[30:0], 1'b0};
               pix_b_d = sh_b_q[31]; sh_b_d = {sh_b_q[30:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         hcnt_q <= '0; vcnt_q <= '0; div_q <= '0; va_q <= BASE_ADDR;
         sh_r_q <= '0; sh_g_q <= '0; sh_b_q <= '0;
         pix_r_q <= 1'b0; pix_g_q <= 1'b0; pix_b_q <= 1'b0; pix_valid_q <= 1'b0;
         hsync_q <= ~SYNC_POL; vsync_q <= ~SYNC_POL; frame_start_q <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d; vcnt_q <= vcnt_d; div_q <= div_d; va_q <= va_d;
         sh_r_q <= sh_r_d; sh_g_q <= sh_g_d; sh_b_q <= sh_b_d;
         pix_r_q <= pix_r_d; pix_g_q <= pix_g_d; pix_b_q <= pix_b_d;
         pix_valid_q <= pix_valid_d;
         hsync_q <= hsync_d; vsync_q <= vsync_d; frame_start_q <= frame_start_d;
      end
   end

   assign va_o          = va_q;
   assign pix_r_o       = pix_r_q;
   assign pix_g_o       = pix_g_q;
   assign pix_b_o       = pix_b_q;
   assign pix_valid_o   = pix_valid_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_video_scanout.sv
// +--------------------------------------------------------------------------+
// | tb_video_scanout                                                         |
// | Directed bench: three scanout instances (base 0, base 0x40, PIX_DIV=3).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_video_scanout;

`ifdef SCANOUT_ZOOM2_EN
   localparam int Z = 1;
`else
   localparam int Z = 0;
`endif
   localparam int HACT = 32 << Z;
   localparam int HT   = HACT + 8;
   localparam int VVIS = 24 << Z;
   localparam int VT   = VVIS + 4;
   localparam int TOT  = HT * VT;

   logic        clk = 1'b0;
   logic        reset_n, en;
   logic [31:0] mem_r [0:23];
   logic [31:0] mem_g [0:23];
   logic [31:0] mem_b [0:23];
   logic [31:0] va [3];
   logic [95:0] vd [3];
   logic [2:0]  rgb [3];
   logic        valid [3], hs [3], vs [3], fs [3];
   int          n_total, n_bad;

   always #5 clk = ~clk;

   function automatic logic [31:0] base_of(input int i);
      return (i == 1) ? 32'h40 : 32'h0;
   endfunction

   function automatic logic [95:0] rd_row(input logic [31:0] addr, input logic [31:0] base);
      logic [31:0] w;
      w = (addr - base) >> 2;
      if (w < 32'd24) return {mem_r[w[4:0]], mem_g[w[4:0]], mem_b[w[4:0]]};
      return '0;
   endfunction

   assign vd[0] = rd_row(va[0], 32'h0);
   assign vd[1] = rd_row(va[1], 32'h40);
   assign vd[2] = rd_row(va[2], 32'h0);

   video_scanout #(.BASE_ADDR(32'h0), .PIX_DIV(1)) u_a (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .va_o(va[0]),
      .vdr_i(vd[0][95:64]), .vdg_i(vd[0][63:32]), .vdb_i(vd[0][31:0]),
      .pix_r_o(rgb[0][2]), .pix_g_o(rgb[0][1]), .pix_b_o(rgb[0][0]),
      .pix_valid_o(valid[0]), .hsync_o(hs[0]), .vsync_o(vs[0]), .frame_start_o(fs[0]));

   video_scanout #(.BASE_ADDR(32'h40), .PIX_DIV(1)) u_b (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .va_o(va[1]),
      .vdr_i(vd[1][95:64]), .vdg_i(vd[1][63:32]), .vdb_i(vd[1][31:0]),
      .pix_r_o(rgb[1][2]), .pix_g_o(rgb[1][1]), .pix_b_o(rgb[1][0]),
      .pix_valid_o(valid[1]), .hsync_o(hs[1]), .vsync_o(vs[1]), .frame_start_o(fs[1]));

   video_scanout #(.BASE_ADDR(32'h0), .PIX_DIV(3)) u_c (
      .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .va_o(va[2]),
      .vdr_i(vd[2][95:64]), .vdg_i(vd[2][63:32]), .vdb_i(vd[2][31:0]),
      .pix_r_o(rgb[2][2]), .pix_g_o(rgb[2][1]), .pix_b_o(rgb[2][0]),
      .pix_valid_o(valid[2]), .hsync_o(hs[2]), .vsync_o(vs[2]), .frame_start_o(fs[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected {valid, rgb, hsync, vsync, frame_start} at raster position (h, v).
   function automatic logic [6:0] model(input int h, input int v, input logic f);
      logic       vis;
      logic [2:0] c;
      int         px, row;
      vis = (h < HACT) && (v < VVIS);
      c = 3'b000;
      if (vis) begin
         px  = 31 - (h >> Z);
         row = v >> Z;
         c   = {mem_r[row][px], mem_g[row][px], mem_b[row][px]};
      end
      return {vis, c, !((h >= HACT + 2) && (h < HACT + 6)),
              !((v >= VVIS + 1) && (v < VVIS + 3)), f};
   endfunction

   task automatic chk_idle(input string tag);
      for (int i = 0; i < 3; i++)
         check(tag, {va[i], rgb[i], valid[i], hs[i], vs[i], fs[i]}, {base_of(i), 7'b000_0110});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, h, v, nv, tc;
      n_total = 0;
      n_bad   = 0;
      reset_n = 1'b0;
      en      = 1'b0;
      mem_r[0] = 32'h8000_0001; mem_g[0] = 32'h0; mem_b[0] = 32'hFFFF_FFFF;
      mem_r[1] = 32'hC000_0003; mem_g[1] = 32'h5555_5555; mem_b[1] = 32'h0;
      for (int i = 2; i < 24; i++) begin
         mem_r[i] = 32'h1234_5678 ^ (i * 32'h0101_0101);
         mem_g[i] = 32'h0F0F_3C3C + i;
         mem_b[i] = ~(32'h0000_0001 << i);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      en      = 1'b1;
      repeat (20) @(posedge clk);
      check("run_before_rst", valid[0], 1'b1);
      #3 reset_n = 1'b0;
      #1 chk_idle("async_rst");

      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("prime_va_a", va[0], 32'h0);
      check("prime_va_b", va[1], 32'h40);
      check("prime_valid", valid[0], 1'b0);

      for (int n = 0; n <= 3 * TOT; n++) begin
         @(negedge clk);
         t = n % TOT;
         h = t % HT;
         v = t / HT;
         check("pos_a", {valid[0], rgb[0], hs[0], vs[0], fs[0]}, model(h, v, t == 0));
         check("pos_b", {valid[1], rgb[1], hs[1], vs[1], fs[1]}, model(h, v, t == 0));
         nv = (v + 1) % VT;
         if (h == HT - 1 && nv < VVIS) begin
            check("fetch_va_a", va[0], 32'(4 * (nv >> Z)));
            check("fetch_va_b", va[1], 32'h40 + 32'(4 * (nv >> Z)));
         end
         tc = (n / 3) % TOT;
         check("pos_c", {valid[2], rgb[2], hs[2], vs[2], fs[2]},
               model(tc % HT, tc / HT, (n % 3 == 0) && (tc == 0)));
`ifndef SCANOUT_ZOOM2_EN
         if (n == 0)       check("l0_px0", rgb[0], 3'b101);
         if (n == 1)       check("l0_px1", rgb[0], 3'b001);
         if (n == 31)      check("l0_px31", rgb[0], 3'b101);
         if (n == 32)      check("l0_blank", valid[0], 1'b0);
         if (n == 34)      check("hs_on", hs[0], 1'b0);
         if (n == 38)      check("hs_off", hs[0], 1'b1);
         if (n == 40)      check("l1_px0", rgb[0], 3'b100);
         if (n == 41)      check("l1_px1", rgb[0], 3'b110);
         if (n == 25 * 40) check("vs_on", vs[0], 1'b0);
         if (n == 27 * 40) check("vs_off", vs[0], 1'b1);
         if (n == 1120)    check("fs_period", fs[0], 1'b1);
         if (n == 5)       check("div3_hold", rgb[2], 3'b001);
         if (n == 3360)    check("div3_period", fs[2], 1'b1);
`else
         if (n == 2 * HT)     check("z_l2_px0", rgb[1], 3'b100);
         if (n == 2 * HT + 1) check("z_l2_hold", rgb[1], 3'b100);
         if (n == 2 * HT + 2) check("z_l2_px1", rgb[1], 3'b110);
         if (n == 3 * HT)     check("z_l3_px0", rgb[1], 3'b100);
         if (n == 2 * HT - 1) check("z_va_l1", va[1], 32'h44);
         if (n == 3 * HT - 1) check("z_va_l2", va[1], 32'h44);
`endif
      end

      repeat (5 * HT + 10) @(negedge clk);
      check("pre_drop_valid", valid[0], 1'b1);
      en = 1'b0;
      repeat (7) begin
         @(negedge clk);
         chk_idle("idle_en0");
      end
      en = 1'b1;
      @(negedge clk);
      check("restart_prime_va", va[0], 32'h0);
      check("restart_prime_vld", valid[0], 1'b0);
      @(negedge clk);
      check("restart_a", {valid[0], rgb[0], hs[0], vs[0], fs[0]}, 7'b1_101_111);
      check("restart_c", {valid[2], rgb[2], hs[2], vs[2], fs[2]}, 7'b1_101_111);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
